// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, FSM encoding and shifter modes.
// The function codes are also used by the ALU control decoder.
package alu_pkg;

    localparam logic [3:0] ALU_ZERO = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter with its own down-counter.
// out is the next shifted value; done flags the final step.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [XLEN-1:0]          value,
    input  logic [$clog2(XLEN)-1:0]  shamt,
    input  logic [1:0]               mode,
    output logic                     done,
    output logic [XLEN-1:0]          out
);

    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] sreg;
    logic [SW-1:0]   cnt;
    logic [1:0]      mode_q;
    logic [XLEN-1:0] nxt;

    always_comb begin
        nxt = sreg;
        unique case (mode_q)
            SH_SLL:  nxt = {sreg[XLEN-2:0], 1'b0};
            SH_SRL:  nxt = {1'b0, sreg[XLEN-1:1]};
            default: nxt = {sreg[XLEN-1], sreg[XLEN-1:1]};
        endcase
    end

    assign out  = nxt;
    assign done = (cnt == SW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg   <= '0;
            cnt    <= '0;
            mode_q <= SH_SLL;
        end else if (load) begin
            sreg   <= value;
            cnt    <= shamt;
            mode_q <= mode;
        end else if (cnt != '0) begin
            sreg <= nxt;
            cnt  <= cnt - SW'(1);
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops plus serial shifts,
// valid/ready on both sides with a registered result.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_funct,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int SW = $clog2(XLEN);

    logic [1:0]      state;
    logic            accept;
    logic            is_shift;
    logic [SW-1:0]   shamt;
    logic [1:0]      sh_mode;
    logic            sh_load;
    logic            sh_done;
    logic [XLEN-1:0] sh_out;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] imm_res;

    assign in_ready  = (state == S_IDLE) ||
                       (state == S_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign shamt     = op_b[SW-1:0];

    always_comb begin
        is_shift = 1'b0;
        sh_mode  = SH_SRA;
        unique case (1'b1)
            alu_funct == ALU_SLL: begin
                is_shift = 1'b1;
                sh_mode  = SH_SLL;
            end
            alu_funct == ALU_SRL: begin
                is_shift = 1'b1;
                sh_mode  = SH_SRL;
            end
            alu_funct == ALU_SRA: begin
                is_shift = 1'b1;
                sh_mode  = SH_SRA;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alu_funct)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}},
                                 $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            default:  alu_res = '0;
        endcase
    end

    // A zero-length shift passes op_a through in one cycle
    assign imm_res = is_shift ? op_a : alu_res;
    assign sh_load = accept && is_shift && (shamt != '0);

    alu_serial_shifter #(.XLEN(XLEN)) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .value (op_a),
        .shamt (shamt),
        .mode  (sh_mode),
        .done  (sh_done),
        .out   (sh_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            unique case (state)
                S_SHIFT: begin
                    if (sh_done) begin
                        result <= sh_out;
                        zero   <= (sh_out == '0);
                        state  <= S_DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        if (sh_load) begin
                            state <= S_SHIFT;
                        end else begin
                            result <= imm_res;
                            zero   <= (imm_res == '0);
                            state  <= S_DONE;
                        end
                    end else if (state == S_DONE && out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec.
// Each task drives one scenario and checks inline.
module tb_alu_exec;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_funct;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_funct (alu_funct),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        alu_funct = 4'd0;
        op_a = '0;
        op_b = '0;
        out_ready = 1'b1;
        step();
        step();
        n_checks++;
        if ({out_valid, zero, busy, in_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0001",
                     {out_valid, zero, busy, in_ready});
        end
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_result: got %h want 0", result);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_add_b2b();
        in_valid = 1'b1;
        alu_funct = 4'd1;
        op_a = 32'h0000_0005;
        op_b = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'h4 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL add: got v=%b r=%h z=%b want 1 4 0",
                     out_valid, result, zero);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL add_in_ready: got %b want 1", in_ready);
        end
        alu_funct = 4'd2;
        op_a = 32'd7;
        op_b = 32'd7;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_b2b: got v=%b r=%h z=%b want 1 0 1",
                     out_valid, result, zero);
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after: got v=%b b=%b want 0 0",
                     out_valid, busy);
        end
    endtask

    task automatic test_single_ops();
        logic [3:0]  f [8] = '{4'd4, 4'd10, 4'd13, 4'd6,
                               4'd7, 4'd2, 4'd4, 4'd0};
        logic [31:0] a [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                               32'hF0, 32'hFF00_FF00, 32'd3,
                               32'd1, 32'h1234};
        logic [31:0] b [8] = '{32'd1, 32'd1, 32'd6, 32'h0F,
                               32'h0FF0_0FF0, 32'd5,
                               32'hFFFF_FFFF, 32'h1};
        logic [31:0] e [8] = '{32'd1, 32'd0, 32'd0, 32'hFF,
                               32'h0F00_0F00, 32'hFFFF_FFFE,
                               32'd0, 32'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            alu_funct = f[i];
            op_a = a[i];
            op_b = b[i];
            step();
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || result !== e[i] ||
                zero !== (e[i] == 32'h0)) begin
                n_fail++;
                $display("FAIL op%0d f=%0d: got v=%b r=%h z=%b want r=%h",
                         i, f[i], out_valid, result, zero, e[i]);
            end
            step();
        end
    endtask

    task automatic test_shift(input logic [3:0] fn,
                              input logic [31:0] a,
                              input logic [31:0] b,
                              input logic [31:0] exp,
                              input int lat);
        int cyc;
        bit hold_ok;
        out_ready = 1'b1;
        in_valid = 1'b1;
        alu_funct = fn;
        op_a = a;
        op_b = b;
        step();
        in_valid = 1'b0;
        op_a = 32'h5A5A_1234;
        op_b = 32'h3;
        alu_funct = 4'd1;
        cyc = 1;
        hold_ok = 1'b1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) hold_ok = 1'b0;
            step();
            cyc++;
        end
        n_checks++;
        if (cyc !== lat) begin
            n_fail++;
            $display("FAIL shift_lat f=%0d: got %0d want %0d", fn, cyc, lat);
        end
        n_checks++;
        if (result !== exp || zero !== (exp == 32'h0)) begin
            n_fail++;
            $display("FAIL shift_res f=%0d: got %h want %h", fn, result, exp);
        end
        n_checks++;
        if (!hold_ok) begin
            n_fail++;
            $display("FAIL shift_busy f=%0d: got busy/in_ready wrong want 1/0",
                     fn);
        end
        step();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1;
        alu_funct = 4'd1;
        op_a = 32'd1;
        op_b = 32'd2;
        step();
        alu_funct = 4'd5;
        op_a = 32'h0000_F0F0;
        op_b = 32'h0000_0FF0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || result !== 32'd3 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall%0d: got v=%b r=%h rdy=%b want 1 3 0",
                         i, out_valid, result, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'h0000_FF00) begin
            n_fail++;
            $display("FAIL held_op: got v=%b r=%h want 1 0000ff00",
                     out_valid, result);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_shift();
        out_ready = 1'b1;
        in_valid = 1'b1;
        alu_funct = 4'd3;
        op_a = 32'd1;
        op_b = 32'd20;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, in_ready, zero} !== 4'b0010 ||
            result !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b b=%b rdy=%b r=%h want 0 0 1 0",
                     out_valid, busy, in_ready, result);
        end
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got v=%b b=%b want 0 0",
                     out_valid, busy);
        end
        in_valid = 1'b1;
        alu_funct = 4'd1;
        op_a = 32'd2;
        op_b = 32'd3;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'd5) begin
            n_fail++;
            $display("FAIL post_reset_op: got v=%b r=%h want 1 5",
                     out_valid, result);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add_b2b();
        test_single_ops();
        test_shift(4'd9, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32);
        test_shift(4'd8, 32'h8000_0000, 32'd31, 32'h0000_0001, 32);
        test_shift(4'd3, 32'h1234_5678, 32'h20, 32'h1234_5678, 1);
        test_shift(4'd3, 32'h0000_0001, 32'd4, 32'h0000_0010, 5);
        test_shift(4'd9, 32'h4000_0000, 32'd2, 32'h1000_0000, 3);
        test_shift(4'd3, 32'h8000_0001, 32'd1, 32'h0000_0002, 2);
        test_stall();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU that consumes the 4-bit `alu_funct` code produced by the ALU control decoder, together with two operands, and returns a registered result. Simple ops complete in one cycle. Shifts run on a serial 1-bit-per-cycle shifter to save area. It sits between decode/issue and write-back. Both sides use a valid/ready handshake, so the core stalls naturally on long shifts.

## Interface
- `XLEN`, default 32: operand/result width; must be a power of two, at least 8.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: operation request.
- `in_ready`  out  1: block can accept a request this cycle.
- `alu_funct`  in  4: operation code (see Operation).
- `op_a`  in  XLEN: first operand; the shifted value for shifts.
- `op_b`  in  XLEN: second operand; shift amount is `op_b[$clog2(XLEN)-1:0]`.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer accepts the result.
- `result`  out  XLEN: registered result.
- `zero`  out  1: registered `result == 0`.
- `busy`  out  1: state is not IDLE.

## Operation
- Codes:
  - 0 ZERO → 0
  - 1 ADD → a+b
  - 2 SUB → a−b
  - 3 SLL
  - 4 SLT (signed a<b → 1, else 0)
  - 5 XOR
  - 6 OR
  - 7 AND
  - 8 SRL
  - 9 SRA
  - 10 SLTU (unsigned)
  - 11–15 → result 0, single-cycle, no error indication.
- ADD/SUB wrap modulo 2^XLEN; there is no carry or overflow output.
- Accept occurs when `in_valid && in_ready`. Operands and code are captured only at accept; input changes afterwards are ignored.
- FSM states are IDLE, SHIFT, DONE.
- IDLE, on accept:
  - Non-shift op: compute, load `result`/`zero`, go to DONE.
  - Shift op with shamt = 0: `result = op_a`, go to DONE.
  - Shift op with shamt > 0: load shift register with `op_a`, counter with shamt, go to SHIFT.
- SHIFT: each cycle, shift by one bit and decrement the counter.
  - SLL fills with 0; SRL fills with 0; SRA fills with the captured MSB.
  - When the counter goes 1→0, write `result`/`zero` and go to DONE.
- DONE: `out_valid=1`; `result`/`zero` are held stable until `out_ready`.
  - On handshake without a new accept, go to IDLE.
  - On handshake with a simultaneous new accept, process the new op exactly as from IDLE. This gives back-to-back single-cycle throughput.
- `in_ready = (state==IDLE) || (state==DONE && out_ready)`. This is a combinational path from `out_ready` to `in_ready`.
- `in_valid` while `in_ready=0` is ignored; the requester must hold it.

## Timing
- Reset values: state IDLE, `out_valid=0`, `result=0`, `zero=0`, `busy=0`, `in_ready=1`, counter 0.
- Non-shift and zero-shift ops: `out_valid` rises 1 cycle after accept.
- Shift ops with shamt N>0: `out_valid` rises N+1 cycles after accept. Maximum is XLEN cycles (N = XLEN−1).
- `result` changes only on the cycle that enters DONE.
- Reset asserted mid-SHIFT or in DONE aborts immediately. The pending result is lost and all outputs take their reset values asynchronously.
- `out_ready` held low keeps DONE indefinitely, and `in_ready` stays 0.
- No combinational path from `in_valid`, `alu_funct`, or the operands to any output.

## Structure
- Shared package `alu_pkg`:
  - the `alu_funct` localparams (ZERO..SLTU, values as above), shared with the ALU control decoder;
  - state encoding IDLE/SHIFT/DONE.
- Sub-module `alu_serial_shifter`:
  - Ports: load, value, shamt, mode (SLL/SRL/SRA), done, out.
  - Internally holds the shift register and down-counter.
- Top level holds the FSM, the combinational single-cycle datapath, and the output registers.

## Test plan
- Reset, then ADD a=0x0000_0005, b=0xFFFF_FFFF with `out_ready=1` → 1 cycle later `out_valid=1`, `result=0x0000_0004`, `zero=0`. A second op (SUB 7,7) accepted in the DONE cycle → `result=0`, `zero=1` the next cycle.
- SLT a=0xFFFF_FFFF, b=1 → 1; SLTU on the same operands → 0; code 13 → `result=0`, single-cycle.
- SRA a=0x8000_0000, b=31 → `out_valid` exactly 32 cycles after accept, `result=0xFFFF_FFFF`; `busy=1` and `in_ready=0` throughout. SRL on the same operands → 0x0000_0001.
- SLL a=0x1234_5678, b=0x20 (shamt 0) → `result=0x1234_5678` after 1 cycle. Operand changes during a long shift do not alter the result.
- `out_ready` held low for 10 cycles in DONE → `result` stable, `in_ready=0`, new `in_valid` ignored. Releasing `out_ready` completes the handshake.
- Reset asserted at cycle 5 of a 20-cycle shift → immediate IDLE, `out_valid=0`, `result=0`. The next op after reset release completes normally.
